// File: rtl/lab71_key_pkg.sv
// Shared definitions for the KEY edge controller: register offsets,
// debounce state encoding and default timing.
package lab71_key_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE    = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // 10 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_CNT_W           = 20;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/lab71_key_debounce_chan.sv
// One KEY channel: two-flop synchronizer, debounce counter/FSM and a
// single-cycle press (1 -> 0) event when a new low level is accepted.
module lab71_key_debounce_chan
    import lab71_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic stable,
    output logic counting,
    output logic press_evt
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync_q;
    logic             stable_q, stable_d;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Keys idle high, so everything resets to the released level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b1;
            sync_q   <= 1'b1;
            stable_q <= 1'b1;
            state_q  <= ST_STABLE;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key_raw;
            sync_q   <= sync1_q;
            stable_q <= stable_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        stable_d  = stable_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_evt = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (sync_q != stable_q) begin
                    state_d = ST_COUNTING;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_COUNTING: begin
                if (sync_q == stable_q) begin
                    // Input bounced back before the window expired.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TERM) begin
                    stable_d  = sync_q;
                    state_d   = ST_STABLE;
                    cnt_d     = '0;
                    press_evt = ~sync_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign stable   = stable_q;
    assign counting = (state_q == ST_COUNTING);

endmodule

// File: rtl/lab71_soc_key_edge_controller.sv
// Avalon-MM KEY controller: debounced level, sticky press capture with W1C,
// interrupt mask and per-key debounce status, with a registered read port.
module lab71_soc_key_edge_controller
    import lab71_key_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] stable_w;
    logic [WIDTH-1:0] counting_w;
    logic [WIDTH-1:0] press_w;

    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        lab71_key_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .key_raw   (in_port[gi]),
            .stable    (stable_w[gi]),
            .counting  (counting_w[gi]),
            .press_evt (press_w[gi])
        );
    end

    // Only the low WIDTH bits of a write carry register content.
    if (WIDTH < 32) begin : g_wdata_unused
        logic unused_wdata;
        assign unused_wdata = ^writedata[31:WIDTH];
    end

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        irqmask_d = irqmask_q;
        if (wr_en && address == ADDR_IRQMASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end

        // Clear first, then OR in new presses so a coincident press survives.
        edge_d = edge_q;
        if (wr_en && address == ADDR_EDGE) begin
            edge_d = edge_q & ~writedata[WIDTH-1:0];
        end
        edge_d = edge_d | press_w;

        irq_d = |(edge_q & irqmask_q);

        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = stable_w;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGE:    readdata_d[WIDTH-1:0] = edge_q;
            ADDR_STATUS:  readdata_d[WIDTH-1:0] = counting_w;
            default:      readdata_d            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q  <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irqmask_q  <= irqmask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_lab71_soc_key_edge_controller.sv
// Self-checking bench for the KEY edge controller with DEBOUNCE_CYCLES=4:
// register-access table plus timed sequences for debounce, irq and reset.
module tb_lab71_soc_key_edge_controller;
    import lab71_key_pkg::*;

    localparam int WIDTH = 2;
    localparam int DEB   = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [12];

    lab71_soc_key_edge_controller #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
        end
    endtask

    // Expected value is queued when the address is driven, compared when
    // the registered read data appears one edge later.
    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        logic [31:0] req;
        address = a;
        exp_q.push_back(e);
        step();
        req = exp_q.pop_front();
        $display("rd  %s addr=%0d data=0x%08h", nm, a, readdata);
        check32(nm, readdata, req);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("wr  addr=%0d data=0x%08h", a, d);
    endtask

    initial begin
        vecs[0]  = '{1'b0, ADDR_DATA,    32'h0,        32'h3, "rst_data"};
        vecs[1]  = '{1'b0, ADDR_IRQMASK, 32'h0,        32'h0, "rst_mask"};
        vecs[2]  = '{1'b0, ADDR_EDGE,    32'h0,        32'h0, "rst_edge"};
        vecs[3]  = '{1'b0, ADDR_STATUS,  32'h0,        32'h0, "rst_status"};
        vecs[4]  = '{1'b1, ADDR_IRQMASK, 32'hFFFFFFFF, 32'h0, "wr_mask_all"};
        vecs[5]  = '{1'b0, ADDR_IRQMASK, 32'h0,        32'h3, "mask_width"};
        vecs[6]  = '{1'b1, ADDR_DATA,    32'h0,        32'h0, "wr_data"};
        vecs[7]  = '{1'b0, ADDR_DATA,    32'h0,        32'h3, "data_ro"};
        vecs[8]  = '{1'b1, ADDR_IRQMASK, 32'h0,        32'h0, "wr_mask_zero"};
        vecs[9]  = '{1'b0, ADDR_IRQMASK, 32'h0,        32'h0, "mask_zero"};
        vecs[10] = '{1'b1, ADDR_EDGE,    32'hFFFFFFFF, 32'h0, "wr_edge_clr"};
        vecs[11] = '{1'b0, ADDR_EDGE,    32'h0,        32'h0, "edge_still0"};

        reset_n    = 1'b0;
        address    = ADDR_DATA;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 2'b11;
        #1;
        check32("rst_readdata", readdata, 32'h0);
        check32("rst_irq", {31'b0, irq}, 32'h0);
        step();
        step();
        reset_n = 1'b1;

        // Register map basics
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            else            rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
        check32("irq_idle", {31'b0, irq}, 32'h0);

        // Key0 press: counting seen before edges 4..6, level accepted at edge 6
        in_port = 2'b10;
        for (int k = 1; k <= 6; k++) rd(ADDR_STATUS, (k >= 4) ? 32'h1 : 32'h0, "s2_status");
        rd(ADDR_DATA, 32'h2, "s2_data");
        rd(ADDR_EDGE, 32'h1, "s2_edge");
        check32("s2_irq_masked", {31'b0, irq}, 32'h0);

        // Release does not capture
        in_port = 2'b11;
        repeat (8) step();
        rd(ADDR_DATA, 32'h3, "rel_data");
        rd(ADDR_EDGE, 32'h1, "rel_edge");
        bus_write(ADDR_EDGE, 32'h1);
        rd(ADDR_EDGE, 32'h0, "w1c_edge");

        // Key1 glitch of 3 samples is rejected
        in_port = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            rd(ADDR_STATUS, (k >= 4 && k <= 6) ? 32'h2 : 32'h0, "s3_status");
            if (k == 3) in_port = 2'b11;
        end
        rd(ADDR_DATA, 32'h3, "s3_data");
        rd(ADDR_EDGE, 32'h0, "s3_edge");

        // Masked interrupt follows edgecapture by one edge
        bus_write(ADDR_IRQMASK, 32'h1);
        in_port = 2'b10;
        for (int k = 1; k <= 7; k++) begin
            step();
            check32("s4_irq", {31'b0, irq}, (k == 7) ? 32'h1 : 32'h0);
        end
        bus_write(ADDR_EDGE, 32'h0);
        rd(ADDR_EDGE, 32'h1, "s4_w0_noeffect");
        bus_write(ADDR_EDGE, 32'h1);
        check32("s4_irq_hold", {31'b0, irq}, 32'h1);
        step();
        check32("s4_irq_clear", {31'b0, irq}, 32'h0);
        rd(ADDR_EDGE, 32'h0, "s4_edge_clear");
        in_port = 2'b11;
        repeat (8) step();

        // W1C coinciding with key1 press event: set wins
        in_port = 2'b01;
        repeat (5) step();
        bus_write(ADDR_EDGE, 32'h2);
        rd(ADDR_EDGE, 32'h2, "s5_set_wins");
        in_port = 2'b11;
        repeat (8) step();
        bus_write(ADDR_IRQMASK, 32'h3);
        step();
        check32("s5_irq_key1", {31'b0, irq}, 32'h1);

        // Reset mid-count with key0 held low
        address = ADDR_DATA;
        in_port = 2'b10;
        repeat (4) step();
        check32("s6_pre_rst_data", readdata, 32'h3);
        reset_n = 1'b0;
        #1;
        check32("s6_rst_readdata", readdata, 32'h0);
        check32("s6_rst_irq", {31'b0, irq}, 32'h0);
        step();
        step();
        reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) rd(ADDR_EDGE, (k == 7) ? 32'h1 : 32'h0, "s6_edge");
        rd(ADDR_DATA, 32'h2, "s6_data");
        rd(ADDR_IRQMASK, 32'h0, "s6_mask");
        check32("s6_irq", {31'b0, irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
